// File: rtl/mem_access_unit.sv
// Memory-stage bus master: turns M-stage loads/stores into req/ack bus transactions,
// stalls the pipeline while a transaction is in flight and reports AdEL/AdES/DBE.
module mem_access_unit #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [1:0]  StoreopM,
    input  logic [2:0]  LoadopM,
    input  logic [31:0] ALUoutM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic [31:0] RDM,
    output logic        ExcM,
    output logic [4:0]  ExcCodeM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(WAIT_LIMIT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        exc_flag;
    logic        misaligned;
    logic        start;

    function automatic logic [3:0] store_be(input logic [1:0] op, input logic [1:0] a);
        case (op)
            2'd2:    store_be = 4'b0001 << a;
            2'd1:    store_be = a[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    // Narrow stores replicate their data across every lane; byte enables pick the target.
    function automatic logic [31:0] store_data(input logic [1:0] op, input logic [31:0] d);
        case (op)
            2'd2:    store_data = {4{d[7:0]}};
            2'd1:    store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    always_comb begin
        misaligned = 1'b0;
        if (MemWriteM) begin
            case (StoreopM)
                2'd2:    misaligned = 1'b0;
                2'd1:    misaligned = ALUoutM[0];
                default: misaligned = |ALUoutM[1:0];
            endcase
        end else begin
            case (LoadopM)
                3'd1, 3'd2: misaligned = 1'b0;
                3'd3, 3'd4: misaligned = ALUoutM[0];
                default:    misaligned = |ALUoutM[1:0];
            endcase
        end
    end

    assign start = (state == IDLE) && MemReqM && !misaligned;

    always_comb begin
        StallM   = start || (state == WAIT);
        ExcM     = 1'b0;
        ExcCodeM = 5'd0;
        if (state == IDLE && MemReqM && misaligned) begin
            ExcM     = 1'b1;
            ExcCodeM = MemWriteM ? 5'd5 : 5'd4;
        end else if (state == DONE && exc_flag) begin
            ExcM     = 1'b1;
            ExcCodeM = 5'd7;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            exc_flag  <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
            RDM       <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bus_req   <= 1'b1;
                        bus_we    <= MemWriteM;
                        bus_addr  <= {ALUoutM[31:2], 2'b00};
                        bus_be    <= MemWriteM ? store_be(StoreopM, ALUoutM[1:0]) : 4'b1111;
                        bus_wdata <= store_data(StoreopM, WriteDataM);
                        cnt       <= 8'd0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) RDM <= bus_rdata;
                        state   <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        bus_req  <= 1'b0;
                        exc_flag <= 1'b1;
                        if (!bus_we) RDM <= 32'd0;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    // The instruction leaves M this cycle; its MemReqM is not reissued.
                    exc_flag <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver pushes expected completions, a monitor
// pops them whenever the unit finishes an access (stall release or exception).
module tb_mem_access_unit;

    localparam int WL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReqM, MemWriteM;
    logic [1:0]  StoreopM;
    logic [2:0]  LoadopM;
    logic [31:0] ALUoutM, WriteDataM;
    logic        StallM, ExcM;
    logic [31:0] RDM;
    logic [4:0]  ExcCodeM;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    mem_access_unit #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .reset(reset), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
        .StoreopM(StoreopM), .LoadopM(LoadopM), .ALUoutM(ALUoutM), .WriteDataM(WriteDataM),
        .StallM(StallM), .RDM(RDM), .ExcM(ExcM), .ExcCodeM(ExcCodeM),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        exc;
        logic [4:0]  code;
        logic [31:0] rdm;
        int          stall;
        int          req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          ack_delay = 0;
    logic [31:0] ack_rdata = 32'd0;
    logic        monitor_off = 1'b1;
    logic [31:0] rdm_model = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    // Bus slave: acks in WAIT cycle ack_delay (0 = never); while idle it throws random
    // stray acks plus a guaranteed late ack in the cycle right after DONE.
    initial begin
        int wcnt;
        int since_fall;
        wcnt = 0;
        since_fall = 10;
        bus_ack = 1'b0;
        bus_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_req) begin
                wcnt++;
                since_fall = 0;
                bus_ack = (wcnt == ack_delay);
                bus_rdata = bus_ack ? ack_rdata : $urandom;
            end else begin
                wcnt = 0;
                if (since_fall < 10) since_fall++;
                bus_ack = (since_fall == 2) || ($urandom_range(0, 2) == 0);
                bus_rdata = $urandom;
            end
        end
    end

    // Monitor: measures stall and request lengths, captures bus fields, checks completions.
    initial begin
        int          stall_run;
        int          req_run;
        logic        held_bad;
        logic        cap_we;
        logic [31:0] cap_addr, cap_wdata;
        logic [3:0]  cap_be;
        exp_t        e;
        stall_run = 0;
        req_run = 0;
        held_bad = 1'b0;
        cap_we = 1'b0;
        cap_addr = 32'd0;
        cap_wdata = 32'd0;
        cap_be = 4'd0;
        forever begin
            @(negedge clk);
            if (monitor_off) begin
                stall_run = 0;
                req_run = 0;
                held_bad = 1'b0;
            end else begin
                if (bus_req) begin
                    if (req_run == 0) begin
                        cap_we = bus_we;
                        cap_addr = bus_addr;
                        cap_be = bus_be;
                        cap_wdata = bus_wdata;
                    end else if (bus_we !== cap_we || bus_addr !== cap_addr ||
                                 bus_be !== cap_be || bus_wdata !== cap_wdata) begin
                        held_bad = 1'b1;
                    end
                    req_run++;
                end
                if (StallM) begin
                    stall_run++;
                end else if (ExcM || stall_run > 0 || req_run > 0) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_completion: exc=%0d stall=%0d req=%0d, expected no access",
                                 ExcM, stall_run, req_run);
                    end else begin
                        e = sb_q.pop_front();
                        chk("exc", 32'(ExcM), 32'(e.exc));
                        chk("exc_code", 32'(ExcCodeM), 32'(e.code));
                        chk("rdm", RDM, e.rdm);
                        chk("stall_cycles", stall_run, e.stall);
                        chk("req_cycles", req_run, e.req);
                        if (e.req > 0) begin
                            chk("bus_we", 32'(cap_we), 32'(e.we));
                            chk("bus_addr", cap_addr, e.addr);
                            chk("bus_be", 32'(cap_be), 32'(e.be));
                            if (e.we) chk("bus_wdata", cap_wdata, e.wdata);
                            chk("bus_held", 32'(held_bad), 32'd0);
                        end
                    end
                    stall_run = 0;
                    req_run = 0;
                    held_bad = 1'b0;
                end
            end
        end
    end

    // Reference model: derives the outcome from access size, alignment and bus latency.
    task automatic issue(input logic we, input logic [1:0] sop, input logic [2:0] lop,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int delay, input logic [31:0] rdata);
        exp_t e;
        int   size;
        int   n;
        bit   acked;
        int   guard;
        if (we) size = (sop == 2) ? 1 : (sop == 1) ? 2 : 4;
        else    size = (lop == 1 || lop == 2) ? 1 : (lop == 3 || lop == 4) ? 2 : 4;
        e.we = we;
        e.addr = addr & 32'hFFFF_FFFC;
        e.be = 4'hF;
        e.wdata = wd;
        if (we && size == 1) begin
            e.be = 4'(1 << (addr % 4));
            e.wdata = wd[7:0] * 32'h0101_0101;
        end else if (we && size == 2) begin
            e.be = 4'(3 << (addr & 2));
            e.wdata = wd[15:0] * 32'h0001_0001;
        end
        if ((addr % size) != 0) begin
            e.exc = 1'b1;
            e.code = we ? 5'd5 : 5'd4;
            e.stall = 0;
            e.req = 0;
        end else begin
            acked = (delay >= 1 && delay <= WL);
            n = acked ? delay : WL;
            e.exc = !acked;
            e.code = acked ? 5'd0 : 5'd7;
            e.stall = n + 1;
            e.req = n;
            if (!we) rdm_model = acked ? rdata : 32'd0;
        end
        e.rdm = rdm_model;
        sb_q.push_back(e);
        ack_delay = delay;
        ack_rdata = rdata;
        MemReqM = 1'b1;
        MemWriteM = we;
        StoreopM = sop;
        LoadopM = lop;
        ALUoutM = addr;
        WriteDataM = wd;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (StallM && guard < 64);
        if (StallM) begin
            n_checks++;
            $display("FAIL stall_release: StallM still 1 after %0d cycles, expected 0", guard);
        end
        @(posedge clk);
        #1;
        MemReqM = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r_we;
        logic [1:0]  r_sop;
        logic [2:0]  r_lop;
        logic [31:0] r_addr, r_wd, r_rd;
        int          r_delay;
        reset = 1'b1;
        MemReqM = 1'b0;
        MemWriteM = 1'b0;
        StoreopM = 2'd0;
        LoadopM = 3'd0;
        ALUoutM = 32'd0;
        WriteDataM = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_bus_req", 32'(bus_req), 32'd0);
        chk("reset_stall", 32'(StallM), 32'd0);
        chk("reset_rdm", RDM, 32'd0);
        chk("reset_bus_addr", bus_addr, 32'd0);
        chk("reset_bus_be", 32'(bus_be), 32'd0);
        chk("reset_exc", 32'(ExcM), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        monitor_off = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("stray_ack_rdm", RDM, 32'd0);

        issue(1'b0, 2'd0, 3'd0, 32'h0000_1004, 32'd0, 1, 32'hDEAD_BEEF);
        issue(1'b1, 2'd2, 3'd0, 32'h0000_2003, 32'h1234_5678, 2, 32'h0);
        issue(1'b1, 2'd1, 3'd0, 32'h0000_2002, 32'h1234_5678, 1, 32'h0);
        issue(1'b0, 2'd0, 3'd0, 32'h0000_3002, 32'd0, 1, 32'h1111_1111);
        issue(1'b1, 2'd1, 3'd0, 32'h0000_3001, 32'h5555_AAAA, 1, 32'h0);
        issue(1'b0, 2'd0, 3'd0, 32'h0000_4000, 32'd0, 0, 32'h2222_2222);
        issue(1'b0, 2'd0, 3'd4, 32'h0000_4006, 32'd0, WL, 32'h8765_4321);
        issue(1'b1, 2'd0, 3'd0, 32'h0000_5008, 32'hA5A5_5A5A, 0, 32'h0);
        issue(1'b0, 2'd0, 3'd2, 32'h0000_6003, 32'd0, 3, 32'hCAFE_F00D);

        // Reset while a load is waiting on the bus.
        monitor_off = 1'b1;
        ack_delay = 0;
        MemReqM = 1'b1;
        MemWriteM = 1'b0;
        LoadopM = 3'd0;
        ALUoutM = 32'h0000_7000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midwait_bus_req", 32'(bus_req), 32'd1);
        reset = 1'b1;
        MemReqM = 1'b0;
        @(posedge clk); #1;
        chk("midwait_reset_bus_req", 32'(bus_req), 32'd0);
        chk("midwait_reset_stall", 32'(StallM), 32'd0);
        chk("midwait_reset_rdm", RDM, 32'd0);
        chk("midwait_reset_bus_be", 32'(bus_be), 32'd0);
        reset = 1'b0;
        rdm_model = 32'd0;
        @(posedge clk); #1;
        monitor_off = 1'b0;

        for (int i = 0; i < 200; i++) begin
            r_we = 1'($urandom_range(0, 1));
            r_sop = 2'($urandom_range(0, 3));
            r_lop = 3'($urandom_range(0, 7));
            r_addr = $urandom;
            r_wd = $urandom;
            r_rd = $urandom;
            r_delay = $urandom_range(0, 6);
            issue(r_we, r_sop, r_lop, r_addr, r_wd, r_delay, r_rd);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (4) begin @(posedge clk); #1; end
        chk("queue_drained", sb_q.size(), 32'd0);
        chk("final_bus_req", 32'(bus_req), 32'd0);
        chk("final_rdm", RDM, rdm_model);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage bus master for the pipelined MIPS core: issues load and store transactions on a req/ack data bus and stalls the pipeline until the bus responds. Stores are converted into aligned word writes with byte enables and lane-replicated data. Loads return the raw 32-bit word as `RDM`, which the M/W pipeline register carries to `RDW`; extraction and extension happen in write-back. Address-alignment errors and bus timeouts are reported as exceptions to the exception logic.

## Interface
- `WAIT_LIMIT`, 16: maximum number of WAIT cycles without `bus_ack` before a bus error; legal range 1–255.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `MemReqM`  in  1  valid load/store in M; held stable while `StallM`=1
- `MemWriteM`  in  1  1=store, 0=load
- `StoreopM`  in  2  0=sw, 1=sh, 2=sb (3 treated as sw)
- `LoadopM`  in  3  0=lw, 1=lbu, 2=lb, 3=lhu, 4=lh (others treated as lw)
- `ALUoutM`  in  32  byte address
- `WriteDataM`  in  32  store data (rt)
- `StallM`  out  1  freeze F/D/E/M
- `RDM`  out  32  raw read word
- `ExcM`  out  1  exception valid
- `ExcCodeM`  out  5  4=AdEL, 5=AdES, 7=DBE
- `bus_req`  out  1  transaction request, registered
- `bus_we`  out  1  write
- `bus_addr`  out  32  `{ALUoutM[31:2],2'b00}`
- `bus_be`  out  4  byte enables
- `bus_wdata`  out  32  write data
- `bus_ack`  in  1  one-cycle completion strobe
- `bus_rdata`  in  32  read data, valid with `bus_ack`

## Operation
- States are IDLE, WAIT and DONE. On reset: state=IDLE, `bus_req`=0, `bus_we`=0, `bus_addr`/`bus_be`/`bus_wdata`=0, `RDM`=0, timeout counter=0, DONE-exception flag=0.
- Misalignment is combinational on the inputs:
  - lw/sw: `ALUoutM[1:0]`≠0.
  - lh/lhu/sh: `ALUoutM[0]`=1.
- **IDLE**
  - `MemReqM`=1 and misaligned: no transaction. `ExcM`=1 and `ExcCodeM`=4 (load) or 5 (store) in the same cycle, `StallM`=0, state stays IDLE.
  - `MemReqM`=1 and aligned: `StallM`=1. At the edge, register the bus outputs, set `bus_req`=1, counter=0, and go to WAIT.
- **Byte lanes**
  - Loads: `bus_be`=1111.
  - sw: `bus_be`=1111, data=`WriteDataM`.
  - sh: `bus_be`=1100 if `ALUoutM[1]` else 0011, data=`{2{WriteDataM[15:0]}}`.
  - sb: `bus_be`=0001<<`ALUoutM[1:0]`, data=`{4{WriteDataM[7:0]}}`.
- **WAIT**
  - `StallM`=1 and bus outputs are held.
  - `bus_ack`=1: drop `bus_req`. For a load, `RDM`<=`bus_rdata`. Go to DONE.
  - No ack and counter=`WAIT_LIMIT`-1: drop `bus_req`, set the DONE-exception flag, for a load set `RDM`<=0, go to DONE. Otherwise counter+1.
- **DONE**
  - `StallM`=0 so the instruction advances.
  - `ExcM`=flag, `ExcCodeM`=7 if flag set.
  - The still-present `MemReqM` is not reissued.
  - Next state is IDLE; the flag clears.
- `ExcCodeM`=0 whenever `ExcM`=0.
- `bus_ack` outside WAIT is ignored.
- Stores never modify `RDM`. `RDM` holds its value until the next load completes.
- Reset in any state returns to IDLE with all registered outputs at reset values at the next edge. An in-flight bus transaction is abandoned.

## Timing
- Zero-wait bus (ack in the first WAIT cycle): 2 stall cycles (IDLE request cycle plus WAIT), then DONE.
- With ack in WAIT cycle n (n≥1): n+1 stall cycles.
- `bus_req` rises one cycle after the request is seen and stays high for exactly the WAIT cycles.
- `RDM` is valid from the DONE cycle onward, aligned with `StallM` falling.
- Timeout: `bus_req` is high for `WAIT_LIMIT` cycles; DBE is reported in the DONE cycle.
- Misaligned access: 0 stall cycles, no bus activity.
- Back-to-back memory ops: every op passes through DONE → IDLE, so at most one request per 3 cycles.

## Test plan
- **Reset:** assert reset during WAIT with `bus_req`=1 → next cycle `bus_req`=0, `StallM`=0, `RDM`=0, state IDLE.
- **Load, zero-wait:** lw at 0x0000_1004, ack with `bus_rdata`=0xDEADBEEF in the first WAIT cycle → `bus_addr`=0x1004, `bus_be`=1111, `StallM` high for 2 cycles, `RDM`=0xDEADBEEF in DONE.
- **Store lanes:** sb at 0x..03 with data 0x12345678 → `bus_be`=1000, `bus_wdata`=0x78787878. sh at 0x..02 → `bus_be`=1100, `bus_wdata`=0x56785678. `RDM` unchanged in both cases.
- **Misaligned:** lw at 0x..02 → `ExcM`=1, code 4, `StallM`=0, `bus_req` stays 0. sh at 0x..01 → code 5.
- **Timeout:** `WAIT_LIMIT`=4, no ack → `bus_req` high for exactly 4 cycles, then DONE with `ExcM`=1, code 7, `RDM`=0.
- **Stray and late ack:** a stray `bus_ack` in IDLE has no effect. An ack arriving on the cycle after a DONE state is ignored and does not start a new request.
